hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard and forwarding unit for the in-order MIPS pipeline. It replaces the fixed EX/MEM compare logic with a registered shadow pipeline of in-flight register writers. Each writer carries a ready countdown, so the unit supports any forwarding depth and any load latency. It sits beside the ID stage and drives the operand-forwarding muxes, the PC/IF-ID write enable and a stall performance counter.

## Interface
- DEPTH, 2: number of forwardable stages after ID (stage 1 = EX, stage 2 = MEM, ...); legal range 1..8.
- LOAD_LATENCY, 1: stages a load spends before its data is forwardable; legal range 0..DEPTH-1.
- REG_ADDR_W, 5: register address width.
- CNT_W, 32: performance counter width.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- id_valid  input  1  ID holds a real instruction.
- id_rs, id_rt  input  REG_ADDR_W  source register addresses.
- id_uses_rs, id_uses_rt  input  1  the instruction reads that source.
- id_wreg  input  1  the instruction writes a register.
- id_waddr  input  REG_ADDR_W  destination register (already rt/rd-muxed).
- id_is_load  input  1  destination value comes from memory.
- flush  input  1  squash the ID instruction (taken branch/jump redirect).
- ext_stall  input  1  whole-pipeline freeze (memory not ready).
- stall  output  1  hazard stall; holds PC and IF/ID.
- issue  output  1  ID instruction advances into stage 1 this cycle.
- fwd_rs_sel, fwd_rt_sel  output  SEL_W=$clog2(DEPTH+1)  operand source: 0 = register file, k = stage k result bus.
- stall_cycles  output  CNT_W  saturating count of cycles with stall=1.

## Operation
- State: DEPTH entries {valid, waddr, rem}. rem is $clog2(LOAD_LATENCY+1) bits wide, with a minimum of 1.
- Operand match for rs: consider the operand only if id_uses_rs=1 and rs≠0. The matching entry is the youngest valid entry (lowest k) with waddr == rs.
  - Matching entry has rem=0: fwd_rs_sel = k.
  - Matching entry has rem≠0: rs_hazard = 1.
  - No match: fwd_rs_sel = 0.
  - rt is handled identically.
- Only the youngest match counts. An older ready entry for the same register is never selected.
- stall = id_valid & (rs_hazard | rt_hazard). This path is combinational and independent of ext_stall and flush.
- issue = id_valid & !stall & !flush & !ext_stall.
- On each rising edge with ext_stall=0:
  - Entry k+1 ← entry k, with rem saturating-decremented to 0.
  - Entry 1 ← {id_wreg & id_waddr≠0, id_waddr, id_is_load ? LOAD_LATENCY : 0} if issue=1. Otherwise entry 1 receives a bubble (valid=0).
  - Entry DEPTH is discarded. Its write reaches the register file, which is write-before-read.
- ext_stall=1: all entries hold, rem counters are not decremented, and no bubble is inserted.
- stall_cycles increments when stall=1 and holds at all-ones.
- Register 0 is never entered as valid and never matched.

## Timing
- stall, issue and the fwd_*_sel outputs are combinational from the current entries and ID inputs, with zero-cycle latency. Entries update at the next edge.
- A load issued in cycle t becomes forwardable in cycle t+1+LOAD_LATENCY from stage 1+LOAD_LATENCY.
  - A dependent instruction in ID stalls for exactly LOAD_LATENCY cycles when it immediately follows the load.
  - DEPTH=2, LOAD_LATENCY=1 reproduces the classic single load-use bubble.
- An ALU result is forwardable from stage 1 in the cycle after issue, with no stall.
- Reset (rst_n=0 at an edge): all entries invalid, rem=0, stall_cycles=0. On the cycle after reset, stall=0 and fwd_*_sel=0 regardless of ID inputs.
  - Reset mid-stall drops every in-flight entry.
- Simultaneous stall and flush: stall still reads 1, issue=0, and a bubble is inserted. The squashed instruction never enters.
- Simultaneous ext_stall and hazard: stall=1, state frozen, stall_cycles still counts.

## Structure
- Shared package `hazard_pkg`:
  - typedef hz_entry_t {valid, waddr, rem}.
  - Constant FWD_SEL_RF = 0.
  - Function for SEL_W.
- Sub-module `forward_select`: combinational priority finder over the entry vector for one source operand. Outputs sel and hazard. Instantiated twice, for rs and rt.
- Top level holds the entry shift register, the bubble/freeze logic and the counter.

## Test plan
- ALU chain, DEPTH=2: issue add $3 then add $4,$3,$3 → fwd_rs_sel=1, fwd_rt_sel=1, stall=0. Instructions one further apart → sel=2.
- Load-use, DEPTH=2, LATENCY=1: lw $5 then add $6,$5,$0:
  - stall=1 for 1 cycle, then fwd_rs_sel=2.
  - stall_cycles=1.
  - With DEPTH=4, LATENCY=3: 3 stall cycles, then sel=4.
- Youngest-wins: add $7 (stage 2), then addi $7 (stage 1), reading $7 → sel=1. The same case with the younger writer being lw → stall=1.
- $0 and unused operands: writer and reader on $0, or id_uses_rt=0 with a matching rt → sel=0, stall=0. The entry is inserted invalid.
- ext_stall held 3 cycles with a pending load → entries and rem frozen and stall stays 1. Release → resumes with the same remaining latency.
- Reset asserted during a load-use stall → next cycle stall=0, stall_cycles=0, and a reader of the load register selects 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard and its operand finders.
// Latency: n/a (types, constants and elaboration-time functions only).
// Backpressure: n/a.
package hazard_pkg;

  // Widest register address an entry can hold (REG_ADDR_W must not exceed it).
  localparam int HZ_ADDR_W = 8;

  // Countdown field sized for the largest legal LOAD_LATENCY (7, since DEPTH <= 8).
  // Only values 0..LOAD_LATENCY are ever stored, so the upper bits stay zero
  // for small latencies and fold away in synthesis.
  localparam int HZ_REM_W = 3;

  // Forwarding select value meaning "take the operand from the register file".
  localparam int FWD_SEL_RF = 0;

  // One in-flight register writer.
  typedef struct packed {
    logic                 valid;
    logic [HZ_ADDR_W-1:0] waddr;
    logic [HZ_REM_W-1:0]  rem;
  } hz_entry_t;

  // Width of a forwarding select: values 0 (register file) up to DEPTH.
  function automatic int hzSelW(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_forward_select.sv
// Finds the youngest in-flight writer of one source operand; reports its stage or a hazard.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller turns hazard into a stall.
module forward_select
  import hazard_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = hzSelW(DEPTH)
) (
  input  hz_entry_t [DEPTH-1:0]      entries,
  input  logic      [REG_ADDR_W-1:0] src,
  input  logic                       uses,
  output logic      [SEL_W-1:0]      sel,
  output logic                       hazard
);

  // Scan oldest to youngest so the youngest matching writer has the final say;
  // an older ready copy of the same register must never win over a younger one.
  always_comb begin
    sel    = SEL_W'(FWD_SEL_RF);
    hazard = 1'b0;
    if (uses && (src != '0)) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (entries[k-1].valid && (entries[k-1].waddr == HZ_ADDR_W'(src))) begin
          if (entries[k-1].rem == '0) begin
            sel    = SEL_W'(k);
            hazard = 1'b0;
          end else begin
            sel    = SEL_W'(FWD_SEL_RF);
            hazard = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit: shadow pipeline of in-flight writers drives forwarding selects and stall.
// Latency: stall/issue/fwd selects are combinational from ID inputs; entries advance on the next edge.
// Backpressure: stall holds PC and IF/ID; ext_stall freezes every entry and inserts no bubble.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int DEPTH        = 2,
  parameter  int LOAD_LATENCY = 1,
  parameter  int REG_ADDR_W   = 5,
  parameter  int CNT_W        = 32,
  localparam int SEL_W        = hzSelW(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_wreg,
  input  logic [REG_ADDR_W-1:0] id_waddr,
  input  logic                  id_is_load,
  input  logic                  flush,
  input  logic                  ext_stall,
  output logic                  stall,
  output logic                  issue,
  output logic [SEL_W-1:0]      fwd_rs_sel,
  output logic [SEL_W-1:0]      fwd_rt_sel,
  output logic [CNT_W-1:0]      stall_cycles
);

  // entries[k-1] mirrors pipeline stage k (stage 1 = EX).
  hz_entry_t [DEPTH-1:0] entries;
  hz_entry_t             newEntry;
  logic                  rsHazard;
  logic                  rtHazard;

  forward_select #(
    .DEPTH      (DEPTH),
    .REG_ADDR_W (REG_ADDR_W),
    .SEL_W      (SEL_W)
  ) rsFinder (
    .entries (entries),
    .src     (id_rs),
    .uses    (id_uses_rs),
    .sel     (fwd_rs_sel),
    .hazard  (rsHazard)
  );

  forward_select #(
    .DEPTH      (DEPTH),
    .REG_ADDR_W (REG_ADDR_W),
    .SEL_W      (SEL_W)
  ) rtFinder (
    .entries (entries),
    .src     (id_rt),
    .uses    (id_uses_rt),
    .sel     (fwd_rt_sel),
    .hazard  (rtHazard)
  );

  // Hazard stall is independent of flush/ext_stall so the counter sees every dependent cycle.
  assign stall = id_valid & (rsHazard | rtHazard);
  assign issue = id_valid & ~stall & ~flush & ~ext_stall;

  // Build the stage-1 entry: a bubble unless the ID instruction really issues; $0 writers stay invalid.
  always_comb begin
    newEntry = '0;
    if (issue) begin
      newEntry.valid = id_wreg & (id_waddr != '0);
      newEntry.waddr = HZ_ADDR_W'(id_waddr);
      newEntry.rem   = id_is_load ? HZ_REM_W'(LOAD_LATENCY) : '0;
    end
  end

  // Shift writers one stage per unfrozen edge, counting load latency down; the last stage drops out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entries <= '0;
    end else if (!ext_stall) begin
      entries[0] <= newEntry;
      for (int k = 1; k < DEPTH; k++) begin
        entries[k].valid <= entries[k-1].valid;
        entries[k].waddr <= entries[k-1].waddr;
        entries[k].rem   <= (entries[k-1].rem != '0) ? (entries[k-1].rem - HZ_REM_W'(1)) : '0;
      end
    end
  end

  // Saturating count of hazard-stall cycles, including those overlapping an external freeze.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: two scoreboards (DEPTH=2/LAT=1 and DEPTH=4/LAT=3) driven with shared stimulus.
// Latency: outputs compared 3 time units after each rising edge against a writer-list model.
// Backpressure: the model reproduces stall, issue, flush and ext_stall behaviour per instance.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, id_valid, id_uses_rs, id_uses_rt, id_wreg, id_is_load, flush, ext_stall;
  logic [4:0] id_rs, id_rt, id_waddr;
  logic       stall2, issue2, stall4, issue4;
  logic [1:0] rsSel2, rtSel2;
  logic [2:0] rsSel4, rtSel4;
  logic [31:0] cnt2, cnt4;

  hazard_scoreboard #(.DEPTH(2), .LOAD_LATENCY(1), .REG_ADDR_W(5), .CNT_W(32)) u2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wreg(id_wreg), .id_waddr(id_waddr),
    .id_is_load(id_is_load), .flush(flush), .ext_stall(ext_stall), .stall(stall2), .issue(issue2),
    .fwd_rs_sel(rsSel2), .fwd_rt_sel(rtSel2), .stall_cycles(cnt2));

  hazard_scoreboard #(.DEPTH(4), .LOAD_LATENCY(3), .REG_ADDR_W(5), .CNT_W(32)) u4 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wreg(id_wreg), .id_waddr(id_waddr),
    .id_is_load(id_is_load), .flush(flush), .ext_stall(ext_stall), .stall(stall4), .issue(issue4),
    .fwd_rs_sel(rsSel4), .fwd_rt_sel(rtSel4), .stall_cycles(cnt4));

  // Model: every issued register write remembered with the pipeline time it issued.
  typedef struct {
    logic [4:0] addr;
    bit         isLoad;
    int         t;
  } wr_t;

  wr_t q0[$];
  wr_t q1[$];
  int  ptime[2];
  int  cntM[2];
  bit  stallM[2];
  bit  issueM[2];
  int  rsM[2];
  int  rtM[2];
  int  checks = 0;
  int  passes = 0;

  function automatic int depthOf(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic int latOf(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Youngest writer of src still inside the forwarding window decides: ready -> its stage, else hazard.
  function automatic void lookup(input int d, input logic [4:0] src, input logic uses,
                                 output int sel, output bit hz);
    int best;
    bit bestLoad;
    int n;
    sel = 0;
    hz = 1'b0;
    best = 0;
    bestLoad = 1'b0;
    if (!uses || src == 5'd0) return;
    n = (d == 0) ? q0.size() : q1.size();
    for (int i = 0; i < n; i++) begin
      wr_t w;
      int age;
      w = (d == 0) ? q0[i] : q1[i];
      age = ptime[d] - w.t + 1;
      if (w.addr == src && age >= 1 && age <= depthOf(d) && (best == 0 || age < best)) begin
        best = age;
        bestLoad = w.isLoad;
      end
    end
    if (best == 0) return;
    if (bestLoad && (best - 1) < latOf(d)) hz = 1'b1;
    else sel = best;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Compute model outputs for the current ID inputs and compare both instances.
  task automatic settle();
    bit h1, h2;
    #2;
    for (int d = 0; d < 2; d++) begin
      lookup(d, id_rs, id_uses_rs, rsM[d], h1);
      lookup(d, id_rt, id_uses_rt, rtM[d], h2);
      stallM[d] = id_valid && (h1 || h2);
      issueM[d] = id_valid && !stallM[d] && !flush && !ext_stall;
    end
    chk("u2.stall", 32'(stall2), 32'(stallM[0]));
    chk("u2.issue", 32'(issue2), 32'(issueM[0]));
    chk("u2.rs_sel", 32'(rsSel2), 32'(rsM[0]));
    chk("u2.rt_sel", 32'(rtSel2), 32'(rtM[0]));
    chk("u2.stall_cycles", cnt2, 32'(cntM[0]));
    chk("u4.stall", 32'(stall4), 32'(stallM[1]));
    chk("u4.issue", 32'(issue4), 32'(issueM[1]));
    chk("u4.rs_sel", 32'(rsSel4), 32'(rsM[1]));
    chk("u4.rt_sel", 32'(rtSel4), 32'(rtM[1]));
    chk("u4.stall_cycles", cnt4, 32'(cntM[1]));
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    wr_t w;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        if (d == 0) q0.delete(); else q1.delete();
        cntM[d] = 0;
      end else begin
        if (stallM[d]) cntM[d]++;
        if (!ext_stall) begin
          ptime[d]++;
          if (issueM[d] && id_wreg && id_waddr != 5'd0) begin
            w.addr = id_waddr;
            w.isLoad = id_is_load;
            w.t = ptime[d];
            if (d == 0) q0.push_back(w); else q1.push_back(w);
          end
        end
      end
    end
    while (q0.size() > 0 && ptime[0] - q0[0].t + 1 > 8) q0.delete(0);
    while (q1.size() > 0 && ptime[1] - q1[0].t + 1 > 8) q1.delete(0);
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic setId(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input bit w, input int wa, input bit ld);
    id_valid = v;
    id_rs = 5'(rs);
    id_rt = 5'(rt);
    id_uses_rs = urs;
    id_uses_rt = urt;
    id_wreg = w;
    id_waddr = 5'(wa);
    id_is_load = ld;
  endtask

  task automatic drain();
    setId(0, 0, 0, 0, 0, 0, 0, 0);
    flush = 1'b0;
    ext_stall = 1'b0;
    for (int i = 0; i < 5; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ptime = '{0, 0};
    cntM = '{0, 0};
    stallM = '{0, 0};
    issueM = '{0, 0};
    rst_n = 1'b0;
    flush = 1'b0;
    ext_stall = 1'b0;
    setId(1, 3, 3, 1, 1, 1, 3, 1);
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state, with ID presenting a reader of registers nobody writes yet.
    settle();
    chk("rst.stall2", 32'(stall2), 32'd0);
    chk("rst.sel4", 32'(rsSel4), 32'd0);
    chk("rst.cnt2", cnt2, 32'd0);
    setId(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // ALU chain: add $3 ; add $4,$3,$3 ; add $8,$3,$0.
    setId(1, 1, 2, 1, 1, 1, 3, 0); step();
    setId(1, 3, 3, 1, 1, 1, 4, 0); settle();
    chk("alu.rs2", 32'(rsSel2), 32'd1);
    chk("alu.rt2", 32'(rtSel2), 32'd1);
    chk("alu.stall2", 32'(stall2), 32'd0);
    tick();
    setId(1, 3, 0, 1, 1, 1, 8, 0); settle();
    chk("alu.far2", 32'(rsSel2), 32'd2);
    chk("alu.far4", 32'(rsSel4), 32'd2);
    tick();

    // Load-use: lw $5 ; add $6,$5,$0 held in ID.
    drain();
    setId(1, 1, 0, 1, 0, 1, 5, 1); step();
    setId(1, 5, 0, 1, 1, 1, 6, 0); settle();
    chk("lu.stall2", 32'(stall2), 32'd1);
    chk("lu.stall4a", 32'(stall4), 32'd1);
    tick(); settle();
    chk("lu.nostall2", 32'(stall2), 32'd0);
    chk("lu.sel2", 32'(rsSel2), 32'd2);
    chk("lu.cnt2", cnt2, 32'd1);
    chk("lu.stall4b", 32'(stall4), 32'd1);
    tick(); step(); settle();
    chk("lu.sel4", 32'(rsSel4), 32'd4);
    chk("lu.cnt4", cnt4, 32'd3);
    tick();

    // Youngest wins: add $7 ; addi $7 ; read $7.
    drain();
    setId(1, 1, 2, 1, 1, 1, 7, 0); step();
    setId(1, 1, 0, 1, 0, 1, 7, 0); step();
    setId(1, 7, 0, 1, 0, 1, 9, 0); settle();
    chk("yw.sel2", 32'(rsSel2), 32'd1);
    chk("yw.sel4", 32'(rsSel4), 32'd1);
    tick();
    drain();
    setId(1, 1, 2, 1, 1, 1, 7, 0); step();
    setId(1, 1, 0, 1, 0, 1, 7, 1); step();
    setId(1, 7, 0, 1, 0, 1, 9, 0); settle();
    chk("yw.ldstall2", 32'(stall2), 32'd1);
    chk("yw.ldstall4", 32'(stall4), 32'd1);
    tick();

    // $0 writers/readers and an unused rt operand.
    drain();
    setId(1, 1, 0, 1, 0, 1, 0, 1); step();
    setId(1, 0, 0, 1, 1, 1, 10, 0); settle();
    chk("r0.stall2", 32'(stall2), 32'd0);
    chk("r0.sel4", 32'(rsSel4), 32'd0);
    tick();
    setId(1, 1, 0, 1, 0, 1, 9, 1); step();
    setId(1, 0, 9, 1, 0, 1, 11, 0); settle();
    chk("unused.rt2", 32'(rtSel2), 32'd0);
    chk("unused.stall4", 32'(stall4), 32'd0);
    tick();

    // ext_stall freezes a pending load for three cycles.
    drain();
    setId(1, 1, 0, 1, 0, 1, 5, 1); step();
    setId(1, 5, 5, 1, 1, 1, 6, 0);
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("ext.stall2", 32'(stall2), 32'd1);
      tick();
    end
    ext_stall = 1'b0;
    settle();
    chk("ext.resume2", 32'(stall2), 32'd1);
    chk("ext.resume4", 32'(stall4), 32'd1);
    tick(); settle();
    chk("ext.sel2", 32'(rtSel2), 32'd2);
    tick(); step(); step();

    // Stall together with flush: no issue, squashed instruction never enters.
    drain();
    setId(1, 1, 0, 1, 0, 1, 5, 1); step();
    setId(1, 5, 0, 1, 0, 1, 5, 0);
    flush = 1'b1; settle();
    chk("fl.stall2", 32'(stall2), 32'd1);
    chk("fl.issue2", 32'(issue2), 32'd0);
    tick();
    flush = 1'b0;
    step(); step();

    // Reset in the middle of a load-use stall.
    drain();
    setId(1, 1, 0, 1, 0, 1, 5, 1); step();
    setId(1, 5, 0, 1, 0, 1, 6, 0); settle();
    chk("rs.pre2", 32'(stall2), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    chk("rs.stall4", 32'(stall4), 32'd0);
    chk("rs.cnt4", cnt4, 32'd0);
    chk("rs.sel2", 32'(rsSel2), 32'd0);
    tick();

    // Randomized traffic over a small register set.
    for (int i = 0; i < 400; i++) begin
      setId($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
            $urandom_range(0, 7), $urandom_range(0, 9) < 3);
      flush = ($urandom_range(0, 9) == 0);
      ext_stall = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
